smvm_stream_tx: RTL and testbench
=================================

Name: smvm_stream_tx

Overview:
- Transmitter for the SMVM input stream. It is the counterpart of the SMVM engine's `val_in`/`col_in`/`ipv_in`/`in_valid` receiver.
- The host loads a dense vector and a list of nonzeros (value, column, end-of-row flag) into internal buffers, then pulses `start`.
- The block then serialises one frame in order:
  - rows header,
  - cols header,
  - vector beats,
  - two-beat (VAL, IDX) nonzero pairs,
  - a mandatory idle gap.
- Used as the stimulus source in the SMVM subsystem and as the bench driver for SMVM.

Parameters:
- VEC_DEPTH, 128, vector buffer entries (max cols).
- NNZ_DEPTH, 256, nonzero buffer entries.
- K, 4, SMVM ALU group size (used by padding).
- GAP_CYCLES, 8, minimum `out_valid`-low cycles after a frame.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_rows  in  8  matrix row count, sampled at accepted start
- cfg_cols  in  8  matrix column count, sampled at accepted start
- vec_wr_en  in  1  append vec_wr_data to vector buffer
- vec_wr_data  in  8  signed vector element
- nz_wr_en  in  1  append one nonzero entry
- nz_val  in  8  signed matrix value
- nz_col  in  8  column index
- nz_last  in  1  entry is last nonzero of its row
- start  in  1  single-cycle frame request
- val_out  out  8  to SMVM val_in
- col_out  out  3  to SMVM col_in
- ipv_out  out  1  to SMVM ipv_in
- out_valid  out  1  to SMVM in_valid
- busy  out  1  frame in progress (HDR_ROWS..GAP)
- done  out  1  one-cycle pulse on final GAP cycle
- load_err  out  1  sticky error flag

Behaviour:

Reset and output registering:
- Reset (rst_n=0) applies immediately, including mid-frame. All outputs become 0, state goes to IDLE, and both write pointers and load_err are cleared. Buffer contents need not be cleared.
- All stream outputs are registered.
- When out_valid=0, val_out, col_out and ipv_out are driven 0.

Field encoding:
- 8-bit field F (rows, cols, column index) is sent as col_out=F[2:0], ipv_out=F[3], val_out={4'b0,F[7:4]}.

Loading (IDLE only):
- Each vec_wr_en writes at vec_wptr, then increments it. Each nz_wr_en writes {val,col,last} at nz_wptr, then increments it.
- A write when the buffer is full, or any write while busy, is dropped and sets load_err.
- Simultaneous vec_wr_en and nz_wr_en are both accepted.

Start:
- start is accepted in IDLE only if cfg_cols≥1, cfg_cols≤VEC_DEPTH and vec_wptr≥cfg_cols.
- Otherwise start is ignored and load_err is set.
- start while busy is ignored with no error.
- At an accepted start, cfg_rows, cfg_cols and nz_wptr are latched.

States and transitions (one output beat per cycle, out_valid=1 in every state except IDLE and GAP):
- IDLE: an accepted start at edge T causes the first beat to appear at T+1.
- HDR_ROWS: rows encoded. Next state HDR_COLS.
- HDR_COLS: cols encoded. Next state VEC.
- VEC: val_out=vec[i], col_out=0, ipv_out=0, for i=0..cols-1.
  - Next state NZ_VAL, or GAP if nnz=0 (padding does not apply).
- NZ_VAL: val_out=nz_val[j], ipv_out=nz_last[j], col_out=0.
- NZ_IDX: nz_col[j] encoded.
  - Next state NZ_VAL for j+1; after the last entry, PAD_VAL if padding is required, else GAP.
- PAD_VAL / PAD_IDX: zero entry (all fields 0), repeated until the total pair count is a multiple of K.
- GAP: out_valid=0 for exactly GAP_CYCLES cycles. done pulses on the last GAP cycle.
  - On exit, vec_wptr and nz_wptr clear and the block returns to IDLE.

Frame length and edge cases:
- Frame length = 2 + cols + 2·(nnz+pad) beats.
- Vector entries beyond cols are loaded but not sent.
- The host guarantees every row has ≥1 entry with nz_last=1. The block does not check this.
- load_err clears only on reset.

Optional Feature:
- Macro: SMVM_TX_PAD_EN.
- Defined: PAD_VAL/PAD_IDX states exist, and pad = (K − nnz mod K) mod K zero pairs follow the real entries.
- Undefined: padding states are removed and entries are sent exactly as loaded (pad=0).

Test Plan:
1. Basic frame.
   - Stimulus: rows=2, cols=3, vec={5,−1,7}, nz={(3,col1,last0),(−2,col2,last1),(4,col0,last0),(1,col2,last1)}, start.
   - Response: beats: hdr (0,2,0), hdr (0,3,0), 5, −1, 7, then VAL/IDX pairs 3/(1), −2+ipv/(2), 4/(0), 1+ipv/(2).
   - Then GAP_CYCLES low, done pulse, busy low.
2. Encoding.
   - Stimulus: nz_col=0x5A.
   - Response: IDX beat col_out=3'b010, ipv_out=1, val_out=0x05.
   - Also cfg_cols=128: cols beat val_out=0x08, ipv_out=0, col_out=0.
3. Padding with K=4, nnz=5.
   - With SMVM_TX_PAD_EN: 8 pairs, the last 3 all-zero.
   - Without SMVM_TX_PAD_EN: exactly 5 pairs. nnz=4: no padding either way.
4. Overflow.
   - Stimulus: 129 vec writes with VEC_DEPTH=128.
   - Response: load_err=1, 129th dropped.
   - Separately, start with vec_wptr=2 and cfg_cols=3: no out_valid, load_err=1.
5. Busy protection.
   - Stimulus: start and nz_wr_en during a frame.
   - Response: frame unchanged, start ignored, the write sets load_err.
   - After done, pointers read 0 (a new 1-entry load transmits 1 pair).
6. Reset mid-frame.
   - Stimulus: assert rst_n low during NZ_IDX.
   - Response: same cycle out_valid=0, busy=0, load_err=0.
   - After release, IDLE and no beats until a new load and start.

Source files
------------

// File: rtl/smvm_stream_tx.sv
// smvm_stream_tx: serialises one SMVM input frame from host-loaded buffers:
// rows header, cols header, vector beats, (VAL, IDX) nonzero pairs, idle gap.
// Optional feature macro SMVM_TX_PAD_EN: when defined, zero pairs are appended
// so the pair count is a multiple of K; when undefined, pairs go out as loaded.
module smvm_stream_tx #(
    parameter int VEC_DEPTH  = 128,
    parameter int NNZ_DEPTH  = 256,
    parameter int K          = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cfg_rows,
    input  logic [7:0] cfg_cols,
    input  logic       vec_wr_en,
    input  logic [7:0] vec_wr_data,
    input  logic       nz_wr_en,
    input  logic [7:0] nz_val,
    input  logic [7:0] nz_col,
    input  logic       nz_last,
    input  logic       start,
    output logic [7:0] val_out,
    output logic [2:0] col_out,
    output logic       ipv_out,
    output logic       out_valid,
    output logic       busy,
    output logic       done,
    output logic       load_err
);
    localparam int VW  = $clog2(VEC_DEPTH + 1);
    localparam int NW  = $clog2(NNZ_DEPTH + 1);
    localparam int VAW = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1;
    localparam int NAW = (NNZ_DEPTH > 1) ? $clog2(NNZ_DEPTH) : 1;
    localparam int CW  = 16;
`ifdef SMVM_TX_PAD_EN
    localparam int KW  = (K > 1) ? $clog2(K) : 1;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_ROWS,
        S_HDR_COLS,
        S_VEC,
        S_NZ_VAL,
        S_NZ_IDX,
`ifdef SMVM_TX_PAD_EN
        S_PAD_VAL,
        S_PAD_IDX,
`endif
        S_GAP
    } state_t;

    logic [7:0]    vec_mem [VEC_DEPTH];
    logic [16:0]   nz_mem  [NNZ_DEPTH];   // {val, col, last}
    logic [VW-1:0] vec_wptr;
    logic [NW-1:0] nz_wptr;
    logic [7:0]    cols_q;
    logic [NW-1:0] nnz_q;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
`ifdef SMVM_TX_PAD_EN
    logic [KW-1:0] kph, kph_nxt;          // pair count modulo K
`endif

    logic          vec_wr_ok, nz_wr_ok, start_ok, frame_end;
    logic [11:0]   beat;                  // {val, col, ipv} of the next beat
    logic          valid_nxt, done_nxt;
    logic [16:0]   nz_rd;

    // 8-bit field as {val, col, ipv}: col=F[2:0], ipv=F[3], val=F[7:4]
    function automatic logic [11:0] enc(input logic [7:0] f);
        return {4'h0, f[7:4], f[2:0], f[3]};
    endfunction

    assign busy      = (state != S_IDLE);
    assign vec_wr_ok = vec_wr_en && !busy && (vec_wptr != VW'(VEC_DEPTH));
    assign nz_wr_ok  = nz_wr_en && !busy && (nz_wptr != NW'(NNZ_DEPTH));
    assign start_ok  = start && !busy && (cfg_cols != '0)
                       && (32'(cfg_cols) <= 32'(VEC_DEPTH))
                       && (32'(vec_wptr) >= 32'(cfg_cols));
    assign frame_end = (state == S_GAP) && (state_nxt == S_IDLE);
    assign nz_rd     = nz_mem[cnt_nxt[NAW-1:0]];

    // Buffer writes (contents are not reset)
    always_ff @(posedge clk) begin
        if (vec_wr_ok) vec_mem[vec_wptr[VAW-1:0]] <= vec_wr_data;
        if (nz_wr_ok)  nz_mem[nz_wptr[NAW-1:0]]   <= {nz_val, nz_col, nz_last};
    end

    // Write pointers and sticky load error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_wptr <= '0;
            nz_wptr  <= '0;
            load_err <= 1'b0;
        end else begin
            if (frame_end) begin
                vec_wptr <= '0;
                nz_wptr  <= '0;
            end else begin
                if (vec_wr_ok) vec_wptr <= vec_wptr + VW'(1);
                if (nz_wr_ok)  nz_wptr  <= nz_wptr + NW'(1);
            end
            if ((vec_wr_en && !vec_wr_ok) || (nz_wr_en && !nz_wr_ok)
                || (start && !busy && !start_ok))
                load_err <= 1'b1;
        end
    end

    // Next-state and beat counter sequencing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef SMVM_TX_PAD_EN
        kph_nxt   = kph;
`endif
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_HDR_ROWS;
                    cnt_nxt   = '0;
`ifdef SMVM_TX_PAD_EN
                    kph_nxt   = '0;
`endif
                end
            end
            S_HDR_ROWS: state_nxt = S_HDR_COLS;
            S_HDR_COLS: begin
                state_nxt = S_VEC;
                cnt_nxt   = '0;
            end
            S_VEC: begin
                if (cnt == CW'(cols_q) - CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = (nnz_q == '0) ? S_GAP : S_NZ_VAL;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_NZ_VAL: state_nxt = S_NZ_IDX;
            S_NZ_IDX: begin
`ifdef SMVM_TX_PAD_EN
                kph_nxt = (kph == KW'(K - 1)) ? '0 : kph + KW'(1);
`endif
                if (cnt == CW'(nnz_q) - CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_GAP;
`ifdef SMVM_TX_PAD_EN
                    if (kph != KW'(K - 1)) state_nxt = S_PAD_VAL;
`endif
                end else begin
                    state_nxt = S_NZ_VAL;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
`ifdef SMVM_TX_PAD_EN
            S_PAD_VAL: state_nxt = S_PAD_IDX;
            S_PAD_IDX: begin
                kph_nxt   = (kph == KW'(K - 1)) ? '0 : kph + KW'(1);
                state_nxt = (kph == KW'(K - 1)) ? S_GAP : S_PAD_VAL;
            end
`endif
            S_GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Beat content for the state being entered; registered below so the
    // outputs line up with the state register (rows go straight from cfg_rows)
    always_comb begin
        beat      = '0;
        valid_nxt = 1'b0;
        case (state_nxt)
            S_HDR_ROWS: begin beat = enc(cfg_rows); valid_nxt = 1'b1; end
            S_HDR_COLS: begin beat = enc(cols_q);   valid_nxt = 1'b1; end
            S_VEC: begin
                beat      = {vec_mem[cnt_nxt[VAW-1:0]], 4'h0};
                valid_nxt = 1'b1;
            end
            S_NZ_VAL: begin beat = {nz_rd[16:9], 3'b000, nz_rd[0]}; valid_nxt = 1'b1; end
            S_NZ_IDX: begin beat = enc(nz_rd[8:1]);                 valid_nxt = 1'b1; end
`ifdef SMVM_TX_PAD_EN
            S_PAD_VAL, S_PAD_IDX: valid_nxt = 1'b1;
`endif
            default: ;
        endcase
        done_nxt = (state_nxt == S_GAP) && (cnt_nxt == CW'(GAP_CYCLES - 1));
    end

    // State, frame latches and registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
`ifdef SMVM_TX_PAD_EN
            kph       <= '0;
`endif
            cols_q    <= '0;
            nnz_q     <= '0;
            val_out   <= '0;
            col_out   <= '0;
            ipv_out   <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
`ifdef SMVM_TX_PAD_EN
            kph   <= kph_nxt;
`endif
            if (start_ok) begin
                cols_q <= cfg_cols;
                nnz_q  <= nz_wptr;
            end
            {val_out, col_out, ipv_out} <= beat;
            out_valid <= valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Self-checking bench for smvm_stream_tx: expected beats are queued when a
// frame is launched and compared by a monitor on the falling clock edge.
module tb_smvm_stream_tx;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cfg_rows, cfg_cols, vec_wr_data, nz_val, nz_col;
    logic       vec_wr_en, nz_wr_en, nz_last, start;
    logic [7:0] val_out;
    logic [2:0] col_out;
    logic       ipv_out, out_valid, busy, done, load_err;

    smvm_stream_tx #(
        .VEC_DEPTH (128),
        .NNZ_DEPTH (256),
        .K         (4),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_rows   (cfg_rows),
        .cfg_cols   (cfg_cols),
        .vec_wr_en  (vec_wr_en),
        .vec_wr_data(vec_wr_data),
        .nz_wr_en   (nz_wr_en),
        .nz_val     (nz_val),
        .nz_col     (nz_col),
        .nz_last    (nz_last),
        .start      (start),
        .val_out    (val_out),
        .col_out    (col_out),
        .ipv_out    (ipv_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  mv[$];
    logic [16:0] mn[$];
    int          low_run  = 0;
    int          gap_seen = 0;
    logic [11:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] enc(input logic [7:0] f);
        return {4'h0, f[7:4], f[2:0], f[3]};
    endfunction

    // Monitor: every valid beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                low_run = 0;
                chk("beat_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("beat", 32'({val_out, col_out, ipv_out}), 32'(mon_exp));
                end
            end else begin
                low_run++;
                chk("idle_zero", 32'({val_out, col_out, ipv_out}), 32'd0);
            end
            if (done) gap_seen = low_run;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic vec_wr(input logic [7:0] d);
        vec_wr_en = 1'b1; vec_wr_data = d;
        tick();
        vec_wr_en = 1'b0;
    endtask

    task automatic nz_wr(input logic [7:0] v, input logic [7:0] c, input logic l);
        nz_wr_en = 1'b1; nz_val = v; nz_col = c; nz_last = l;
        tick();
        nz_wr_en = 1'b0;
    endtask

    task automatic ld_vec(input logic [7:0] d);
        vec_wr(d);
        mv.push_back(d);
    endtask

    task automatic ld_nz(input logic [7:0] v, input logic [7:0] c, input logic l);
        nz_wr(v, c, l);
        mn.push_back({v, c, l});
    endtask

    task automatic pulse_start(input logic [7:0] r, input logic [7:0] c);
        cfg_rows = r; cfg_cols = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] rows, input logic [7:0] cols);
        int pad;
        exp_q.push_back(enc(rows));
        exp_q.push_back(enc(cols));
        for (int i = 0; i < int'(cols); i++) exp_q.push_back({mv[i], 4'h0});
        for (int j = 0; j < mn.size(); j++) begin
            exp_q.push_back({mn[j][16:9], 3'b000, mn[j][0]});
            exp_q.push_back(enc(mn[j][8:1]));
        end
        pad = 0;
`ifdef SMVM_TX_PAD_EN
        pad = (4 - (mn.size() % 4)) % 4;
`endif
        for (int p = 0; p < 2 * pad; p++) exp_q.push_back(12'h000);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (done) got = 1'b1;
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        if (got) chk({tag, "_gap_len"}, 32'(gap_seen), 32'(GAP));
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        tick();
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
        mv.delete(); mn.delete(); exp_q.delete();
    endtask

    initial begin
        cfg_rows = '0; cfg_cols = '0; vec_wr_data = '0; nz_val = '0; nz_col = '0;
        vec_wr_en = 1'b0; nz_wr_en = 1'b0; nz_last = 1'b0; start = 1'b0;
        tick(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_fields", 32'({val_out, col_out, ipv_out}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame, nnz=4 (no padding either way)
        ld_vec(8'd5); ld_vec(8'hFF); ld_vec(8'd7);
        ld_nz(8'd3, 8'd1, 1'b0); ld_nz(8'hFE, 8'd2, 1'b1);
        ld_nz(8'd4, 8'd0, 1'b0); ld_nz(8'd1, 8'd2, 1'b1);
        push_frame(8'd2, 8'd3);
        pulse_start(8'd2, 8'd3);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 200);
        chk("t1_load_err", 32'(load_err), 32'd0);

        // Vector overflow, cols=128 header, column 0x5A encoding
        do_reset();
        for (int i = 0; i < 128; i++) ld_vec(8'(i * 3 + 1));
        chk("t4_err_full", 32'(load_err), 32'd0);
        vec_wr(8'hAA);
        chk("t4_err_overflow", 32'(load_err), 32'd1);
        ld_nz(8'h11, 8'h5A, 1'b1);
        push_frame(8'd1, 8'd128);
        pulse_start(8'd1, 8'd128);
        wait_done("t2", 600);

        // nnz=5 (padding depends on build)
        do_reset();
        ld_vec(8'h42);
        for (int i = 0; i < 5; i++) ld_nz(8'(i + 1), 8'(i), (i == 4));
        push_frame(8'd1, 8'd1);
        pulse_start(8'd1, 8'd1);
        wait_done("t3", 200);
        chk("t3_load_err", 32'(load_err), 32'd0);

        // Start with too few vector entries is refused
        do_reset();
        vec_wr(8'd1); vec_wr(8'd2);
        pulse_start(8'd1, 8'd3);
        tick(20);
        chk("t4b_busy", 32'(busy), 32'd0);
        chk("t4b_out_valid", 32'(out_valid), 32'd0);
        chk("t4b_load_err", 32'(load_err), 32'd1);

        // Start and write while busy; pointers clear after the frame
        do_reset();
        ld_vec(8'h10); ld_vec(8'h20);
        ld_nz(8'h07, 8'd3, 1'b1); ld_nz(8'h09, 8'd4, 1'b1);
        push_frame(8'd1, 8'd2);
        pulse_start(8'd1, 8'd2);
        tick(2);
        pulse_start(8'd5, 8'd1);
        chk("t5_err_start_busy", 32'(load_err), 32'd0);
        nz_wr(8'h55, 8'd1, 1'b1);
        wait_done("t5a", 200);
        chk("t5_err_write_busy", 32'(load_err), 32'd1);
        mv.delete(); mn.delete();
        ld_vec(8'h33);
        ld_nz(8'h44, 8'd6, 1'b1);
        push_frame(8'd3, 8'd1);
        pulse_start(8'd3, 8'd1);
        wait_done("t5b", 200);

        // Reset asserted while an NZ_IDX beat is on the outputs
        do_reset();
        ld_vec(8'd1); ld_vec(8'd2);
        ld_nz(8'h05, 8'd1, 1'b1); ld_nz(8'h06, 8'd2, 1'b1);
        push_frame(8'd1, 8'd2);
        pulse_start(8'd1, 8'd2);
        vec_wr(8'h99);
        tick(3);
        @(negedge clk);
        #2;
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        chk("t6_pre_idx", 32'({val_out, col_out, ipv_out}), 32'(enc(8'd1)));
        chk("t6_pre_err", 32'(load_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_err", 32'(load_err), 32'd0);
        exp_q.delete(); mv.delete(); mn.delete();
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        ld_vec(8'h7F);
        ld_nz(8'h80, 8'hFF, 1'b1);
        push_frame(8'hFF, 8'd1);
        pulse_start(8'hFF, 8'd1);
        wait_done("t6", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
